pre_add_mult_stage: RTL and testbench

- Front half of the DSP48A1 slice: input pipeline registers, 18-bit D/B pre-adder/subtracter, 18x18 signed multiplier, and M register.
- Feeds the post-adder/subtracter stage with the 36-bit product `m`, the A1/B1/D register values (for the D:A:B concatenation path) and the B cascade output.
- One clock, per-register clock enables, single synchronous active-high reset.

---
 rtl/pre_add_mult_stage_if.sv | 29 ++
 rtl/pre_add_mult_stage.sv | 86 ++++++++
 tb/tb_pre_add_mult_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pre_add_mult_stage_if.sv
// Operand, enable and result bundle for the pre-adder/multiplier front end.
// The master drives operands and enables; the slave (datapath) returns stage values.
interface pre_add_mult_stage_if;
  logic                ce_a;
  logic                ce_b;
  logic                ce_d;
  logic                ce_m;
  logic                ce_opmode;
  logic signed [17:0]  a;
  logic signed [17:0]  b;
  logic signed [17:0]  bcin;
  logic signed [17:0]  d;
  logic        [1:0]   opmode_pre;
  logic signed [17:0]  bcout;
  logic signed [17:0]  a1_q;
  logic signed [17:0]  b1_q;
  logic signed [17:0]  d_q;
  logic signed [35:0]  m;

  modport master (
    output ce_a, ce_b, ce_d, ce_m, ce_opmode, a, b, bcin, d, opmode_pre,
    input  bcout, a1_q, b1_q, d_q, m
  );

  modport slave (
    input  ce_a, ce_b, ce_d, ce_m, ce_opmode, a, b, bcin, d, opmode_pre,
    output bcout, a1_q, b1_q, d_q, m
  );
endinterface

// File: rtl/pre_add_mult_stage.sv
// DSP48A1-style front half: input registers, D/B pre-adder, 18x18 signed multiply, M register.
// Every stage can be bypassed by parameter; a bypassed stage's register is simply not selected.
module pre_add_mult_stage #(
  parameter int    A0REG     = 0,
  parameter int    A1REG     = 1,
  parameter int    B0REG     = 0,
  parameter int    B1REG     = 1,
  parameter int    DREG      = 1,
  parameter int    MREG      = 1,
  parameter int    OPMODEREG = 1,
  parameter string B_INPUT   = "DIRECT"
) (
  input logic                 clk,
  input logic                 rst,
  pre_add_mult_stage_if.slave bus
);

  localparam bit CASCADE = (B_INPUT == "CASCADE");

  // Pre-adder wraps modulo 2^18; carry and borrow are dropped on purpose.
  function automatic logic signed [17:0] pre_add(input logic signed [17:0] dv,
                                                 input logic signed [17:0] bv,
                                                 input logic        [1:0]  op);
    if (!op[0]) return bv;
    return op[1] ? (dv - bv) : (dv + bv);
  endfunction

  logic signed [17:0] b_sel;
  logic signed [17:0] a_p0, b_p0, d_p0;
  logic        [1:0]  op_p0;
  logic signed [17:0] a_p1, b_p1;
  logic signed [35:0] m_p2;

  logic signed [17:0] a0, b0, dq, pre, a1, b1;
  logic        [1:0]  op;
  logic signed [35:0] prod;

  assign b_sel = CASCADE ? bus.bcin : bus.b;

  // Stage 0: input registers (A0, B0, D, opmode)
  assign a0 = (A0REG     != 0) ? a_p0  : bus.a;
  assign b0 = (B0REG     != 0) ? b_p0  : b_sel;
  assign dq = (DREG      != 0) ? d_p0  : bus.d;
  assign op = (OPMODEREG != 0) ? op_p0 : bus.opmode_pre;

  assign pre = pre_add(dq, b0, op);

  // Stage 1: A1 and pre-adder output registers
  assign a1 = (A1REG != 0) ? a_p1 : a0;
  assign b1 = (B1REG != 0) ? b_p1 : pre;

  assign prod = a1 * b1;

  // Stage 2: product register
  assign bus.m = (MREG != 0) ? m_p2 : prod;

  assign bus.bcout = b1;
  assign bus.b1_q  = b1;
  assign bus.a1_q  = a1;
  assign bus.d_q   = dq;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_p0  <= '0;
      b_p0  <= '0;
      d_p0  <= '0;
      op_p0 <= '0;
      a_p1  <= '0;
      b_p1  <= '0;
      m_p2  <= '0;
    end else begin
      if (bus.ce_a) begin
        a_p0 <= bus.a;
        a_p1 <= a0;
      end
      if (bus.ce_b) begin
        b_p0 <= b_sel;
        b_p1 <= pre;
      end
      if (bus.ce_d)      d_p0  <= bus.d;
      if (bus.ce_opmode) op_p0 <= bus.opmode_pre;
      if (bus.ce_m)      m_p2  <= prod;
    end
  end

endmodule

// File: tb/tb_pre_add_mult_stage.sv
// Directed bench for pre_add_mult_stage: default-parameter instance plus a B-cascade instance.
module tb_pre_add_mult_stage;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  pre_add_mult_stage_if bus ();
  pre_add_mult_stage_if bus_c ();

  pre_add_mult_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pre_add_mult_stage #(.B_INPUT("CASCADE")) dut_c (
    .clk (clk),
    .rst (rst),
    .bus (bus_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %09h expected %09h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [17:0] av, input logic [17:0] bv,
                         input logic [17:0] dv, input logic [1:0] opv);
    bus.a          = av;
    bus.b          = bv;
    bus.d          = dv;
    bus.opmode_pre = opv;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    bus.ce_a = 1'b1; bus.ce_b = 1'b1; bus.ce_d = 1'b1; bus.ce_m = 1'b1; bus.ce_opmode = 1'b1;
    bus.bcin = 18'd0;
    set_ops(18'd0, 18'd0, 18'd0, 2'b00);
    bus_c.ce_a = 1'b1; bus_c.ce_b = 1'b1; bus_c.ce_d = 1'b1; bus_c.ce_m = 1'b1;
    bus_c.ce_opmode = 1'b1;
    bus_c.a = 18'd1; bus_c.b = 18'd99; bus_c.bcin = 18'd11; bus_c.d = 18'd0;
    bus_c.opmode_pre = 2'b00;

    tick(2);
    rst = 1'b0;
    check("reset_m",     bus.m, 36'd0);
    check("reset_bcout", $unsigned(bus.bcout), 36'd0);
    check("reset_a1_q",  $unsigned(bus.a1_q), 36'd0);
    check("reset_d_q",   $unsigned(bus.d_q), 36'd0);

    // Plain multiply, B path latency 2
    set_ops(18'd3, 18'd5, 18'd0, 2'b00);
    tick(1);
    check("mul_edge1_m", bus.m, 36'd0);
    check("mul_bcout",   $unsigned(bus.bcout), 36'd5);
    tick(1);
    check("mul_edge2_m", bus.m, 36'd15);

    // Pre-add, D path latency 3
    set_ops(18'd2, 18'd20, 18'd100, 2'b01);
    tick(2);
    check("add_edge2_m", bus.m, 36'd40);
    tick(1);
    check("add_m",    bus.m, 36'd240);
    check("add_b1_q", $unsigned(bus.b1_q), 36'd120);
    check("add_d_q",  $unsigned(bus.d_q), 36'd100);

    // Subtract with borrow wrap: 0 - 1 = 0x3FFFF
    set_ops(18'd7, 18'd1, 18'd0, 2'b11);
    tick(3);
    check("sub_b1_q", $unsigned(bus.b1_q), 36'h3FFFF);
    check("sub_m",    bus.m, 36'hFFFFFFFF9);

    // Signed extremes
    set_ops(18'h20000, 18'h20000, 18'd0, 2'b00);
    tick(3);
    check("ext_min_min", bus.m, 36'h400000000);
    set_ops(18'h1FFFF, 18'h20000, 18'd0, 2'b00);
    tick(2);
    check("ext_max_min", bus.m, 36'hC00020000);

    // Carry wrap: 0x3FFFF + 1 = 0
    set_ops(18'd1, 18'd1, 18'h3FFFF, 2'b01);
    tick(3);
    check("carry_b1_q", $unsigned(bus.b1_q), 36'd0);
    check("carry_m",    bus.m, 36'd0);

    // A enable held low while a changes
    set_ops(18'd4, 18'd2, 18'd0, 2'b00);
    tick(3);
    check("hold_pre_m", bus.m, 36'd8);
    bus.ce_a = 1'b0;
    bus.a    = 18'd9;
    tick(1);
    check("hold_c1_m", bus.m, 36'd8);
    tick(1);
    check("hold_c2_m", bus.m, 36'd8);
    check("hold_a1_q", $unsigned(bus.a1_q), 36'd4);
    bus.ce_a = 1'b1;
    tick(1);
    check("hold_rel1_m", bus.m, 36'd8);
    tick(1);
    check("hold_rel2_m", bus.m, 36'd18);

    // Reset in the middle of a stream clears in-flight data
    set_ops(18'd5, 18'd6, 18'd55, 2'b00);
    tick(2);
    check("pre_rst_m",   bus.m, 36'd30);
    check("pre_rst_d_q", $unsigned(bus.d_q), 36'd55);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_m",     bus.m, 36'd0);
    check("rst_bcout", $unsigned(bus.bcout), 36'd0);
    check("rst_a1_q",  $unsigned(bus.a1_q), 36'd0);
    check("rst_d_q",   $unsigned(bus.d_q), 36'd0);
    set_ops(18'd3, 18'd4, 18'd0, 2'b00);
    tick(1);
    check("post_rst1_m", bus.m, 36'd0);
    tick(1);
    check("post_rst2_m", bus.m, 36'd12);

    // Cascade instance selects bcin over b
    check("casc_m",     bus_c.m, 36'd11);
    check("casc_bcout", $unsigned(bus_c.bcout), 36'd11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
